// File: rtl/ne_pkg.sv
// Shared constants and FSM encodings for the node-element LLR path.
// Widths here are the defaults for the loader and its quantiser.
package ne_pkg;

  localparam int WIDTH        = 6;
  localparam int ADDRESSWIDTH = 9;
  localparam int MEMDEPTH     = 512;
  localparam int LLR_MAX      = (1 << (WIDTH - 1)) - 1;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/ne_llr_quant.sv
// LLR quantiser: arithmetic right shift, then symmetric saturation.
// Most-negative code is never produced so +/- magnitudes stay balanced.
module ne_llr_quant #(
  parameter int IN_WIDTH = 8,
  parameter int WIDTH    = ne_pkg::WIDTH,
  parameter int SHIFT    = 2
) (
  input  logic [IN_WIDTH-1:0] llr_in,
  output logic [WIDTH-1:0]    llr_q
);

  localparam int MAXV = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [IN_WIDTH-1:0] PMAX = IN_WIDTH'(MAXV);
  localparam logic signed [IN_WIDTH-1:0] NMAX = IN_WIDTH'(-MAXV);

  logic signed [IN_WIDTH-1:0] t;

  // shift with sign extension, then clamp to +/-MAXV
  always_comb begin
    t = $signed(llr_in) >>> SHIFT;
    unique case (1'b1)
      (t > PMAX): llr_q = PMAX[WIDTH-1:0];
      (t < NMAX): llr_q = NMAX[WIDTH-1:0];
      default:    llr_q = t[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/ne_llr_write_loader.sv
// Ping-pong loader: quantises streamed LLRs into two RAM banks.
// Bank full flags are raised only once the last word is in RAM.
module ne_llr_write_loader #(
  parameter int WIDTH        = ne_pkg::WIDTH,
  parameter int ADDRESSWIDTH = ne_pkg::ADDRESSWIDTH,
  parameter int MEMDEPTH     = ne_pkg::MEMDEPTH,
  parameter int IN_WIDTH     = 8,
  parameter int SHIFT        = 2,
  parameter int FRAMELEN     = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_WIDTH-1:0]     llr_in,
  input  logic                    llr_valid,
  output logic                    llr_ready,
  input  logic [1:0]              bank_rel,
  output logic [WIDTH-1:0]        DIN,
  output logic [ADDRESSWIDTH-1:0] WA,
  output logic                    wr_in,
  output logic [1:0]              bank_full,
  output logic                    frame_done,
  output logic                    done_bank
);

  import ne_pkg::*;

  localparam int IW = ADDRESSWIDTH - 1;
  localparam int FL = (FRAMELEN > MEMDEPTH / 2) ? MEMDEPTH / 2 : FRAMELEN;
  localparam logic [IW-1:0] LAST = IW'(FL - 1);

  state_e          state, state_n;
  logic            wbank, wbank_n;
  logic [IW-1:0]   idx, idx_n;
  logic            pend, pend_n;
  logic            pbank, pbank_n;
  logic [1:0]      full_n;
  logic            ready_n;
  logic            acc;
  logic [WIDTH-1:0] q;

  ne_llr_quant #(
    .IN_WIDTH (IN_WIDTH),
    .WIDTH    (WIDTH),
    .SHIFT    (SHIFT)
  ) u_quant (
    .llr_in (llr_in),
    .llr_q  (q)
  );

  assign acc = llr_valid & llr_ready;

  // next state: counter, bank toggle, flags (completion beats release)
  always_comb begin
    state_n = state;
    wbank_n = wbank;
    idx_n   = idx;
    pend_n  = 1'b0;
    pbank_n = pbank;
    full_n  = bank_full & ~bank_rel;
    if (pend) full_n[pbank] = 1'b1;
    if (acc) begin
      if (idx == LAST) begin
        idx_n   = '0;
        wbank_n = ~wbank;
        pend_n  = 1'b1;
        pbank_n = wbank;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
    case (state)
      LOAD:    if (pend && full_n[wbank]) state_n = HOLD;
      HOLD:    if (!full_n[wbank]) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // ready for next cycle, from next-state registers only
  always_comb begin
    ready_n = (state_n == LOAD) & ~pend_n & ~full_n[wbank_n];
  end

  // state, flags and registered RAM write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      wbank      <= 1'b0;
      idx        <= '0;
      pend       <= 1'b0;
      pbank      <= 1'b0;
      bank_full  <= 2'b00;
      llr_ready  <= 1'b0;
      wr_in      <= 1'b0;
      DIN        <= '0;
      WA         <= '0;
      frame_done <= 1'b0;
      done_bank  <= 1'b0;
    end else begin
      state      <= state_n;
      wbank      <= wbank_n;
      idx        <= idx_n;
      pend       <= pend_n;
      pbank      <= pbank_n;
      bank_full  <= full_n;
      llr_ready  <= ready_n;
      wr_in      <= acc;
      frame_done <= pend;
      if (acc) begin
        DIN <= q;
        WA  <= {wbank, idx};
      end
      if (pend) done_bank <= pbank;
    end
  end

endmodule

// File: tb/tb_ne_llr_write_loader.sv
// Directed bench for the ping-pong LLR write loader.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ne_llr_write_loader;

  logic       clk;
  logic       rst;
  logic [7:0] llr_in;
  logic       llr_valid;
  logic       llr_ready;
  logic [1:0] bank_rel;
  logic [5:0] DIN;
  logic [8:0] WA;
  logic       wr_in;
  logic [1:0] bank_full;
  logic       frame_done;
  logic       done_bank;

  int nvec = 0;
  int nerr = 0;

  ne_llr_write_loader dut (
    .clk        (clk),
    .rst        (rst),
    .llr_in     (llr_in),
    .llr_valid  (llr_valid),
    .llr_ready  (llr_ready),
    .bank_rel   (bank_rel),
    .DIN        (DIN),
    .WA         (WA),
    .wr_in      (wr_in),
    .bank_full  (bank_full),
    .frame_done (frame_done),
    .done_bank  (done_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one sample; returns 1ns after its accept edge
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    llr_in    = v;
    llr_valid = 1'b1;
    while (!llr_ready && n < 64) begin
      tick();
      n++;
    end
    if (!llr_ready) check("ready_timeout", 32'(llr_ready), 32'd1);
    tick();
    llr_valid = 1'b0;
  endtask

  task automatic pulse_rel(input logic [1:0] r);
    bank_rel = r;
    tick();
    bank_rel = 2'b00;
  endtask

  // expected 6-bit code for input 4*i: value i mod 64 as 6-bit signed, -32 -> -31
  function automatic logic [5:0] stream_exp(input int i);
    int m;
    int v;
    m = i % 64;
    v = (m < 32) ? m : m - 64;
    if (v < -31) v = -31;
    return v[5:0];
  endfunction

  initial begin
    logic [7:0] sat_in  [5];
    logic [5:0] sat_out [5];
    logic [8:0] last_wa;
    sat_in  = '{8'd127, 8'h80, 8'h83, 8'd124, 8'hFC};
    sat_out = '{6'h1F, 6'h21, 6'h21, 6'h1F, 6'h3F};

    rst       = 1'b0;
    llr_in    = '0;
    llr_valid = 1'b0;
    bank_rel  = 2'b00;
    #1;
    check("rst_din",   32'(DIN), 0);
    check("rst_wa",    32'(WA), 0);
    check("rst_wr",    32'(wr_in), 0);
    check("rst_ready", 32'(llr_ready), 0);
    check("rst_full",  32'(bank_full), 0);
    check("rst_fdone", 32'(frame_done), 0);
    check("rst_dbank", 32'(done_bank), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("ready_up", 32'(llr_ready), 1);

    // full frame into bank 0
    for (int i = 0; i < 256; i++) begin
      send(8'(4 * i));
      check("s_wr",  32'(wr_in), 1);
      check("s_wa",  32'(WA), 32'(i));
      check("s_din", 32'(DIN), 32'(stream_exp(i)));
    end
    check("s_last_ready", 32'(llr_ready), 0);
    check("s_last_full",  32'(bank_full), 0);
    check("s_last_fdone", 32'(frame_done), 0);
    tick();
    check("s_cmp_fdone", 32'(frame_done), 1);
    check("s_cmp_full",  32'(bank_full), 32'b01);
    check("s_cmp_dbank", 32'(done_bank), 0);
    check("s_cmp_wr",    32'(wr_in), 0);
    check("s_cmp_ready", 32'(llr_ready), 1);
    tick();
    check("s_fdone_pulse", 32'(frame_done), 0);

    // saturation at start of bank 1
    for (int k = 0; k < 5; k++) begin
      send(sat_in[k]);
      check("sat_wa",  32'(WA), 32'(256 + k));
      check("sat_din", 32'(DIN), 32'(sat_out[k]));
    end
    for (int i = 5; i < 256; i++) send(8'd0);
    check("b1_last_wa", 32'(WA), 511);
    tick();
    check("b1_full",  32'(bank_full), 32'b11);
    check("b1_dbank", 32'(done_bank), 1);
    check("b1_fdone", 32'(frame_done), 1);
    check("b1_ready", 32'(llr_ready), 0);
    tick();
    tick();
    check("hold_ready", 32'(llr_ready), 0);
    check("hold_wr",    32'(wr_in), 0);

    // release bank 0, loading resumes at WA 0
    pulse_rel(2'b01);
    check("rel0_full",  32'(bank_full), 32'b10);
    check("rel0_ready", 32'(llr_ready), 1);
    send(8'd8);
    check("rel0_wa",  32'(WA), 0);
    check("rel0_din", 32'(DIN), 2);

    // finish bank 0 -> both full, hold; free bank 1
    for (int i = 1; i < 256; i++) send(8'd4);
    tick();
    check("b0b_full",  32'(bank_full), 32'b11);
    check("b0b_ready", 32'(llr_ready), 0);
    pulse_rel(2'b10);
    check("rel1_full",  32'(bank_full), 32'b01);
    check("rel1_ready", 32'(llr_ready), 1);

    // release of bank 1 on its own completion edge is dropped
    for (int i = 0; i < 256; i++) send(8'd4);
    check("race_pre_wa", 32'(WA), 511);
    pulse_rel(2'b10);
    check("race_full",  32'(bank_full), 32'b11);
    check("race_fdone", 32'(frame_done), 1);
    check("race_ready", 32'(llr_ready), 0);

    // free bank 0, then spurious release of the empty bank 0
    pulse_rel(2'b01);
    check("rel0b_full", 32'(bank_full), 32'b10);
    pulse_rel(2'b01);
    check("spur_full",  32'(bank_full), 32'b10);
    check("spur_ready", 32'(llr_ready), 1);

    // valid bubbles across a whole bank 0 frame
    last_wa = WA;
    for (int i = 0; i < 256; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        tick();
        check("bub_nowr", 32'(wr_in), 0);
        check("bub_hold", 32'(WA), 32'(last_wa));
      end
      send(8'(i));
      check("bub_wa", 32'(WA), 32'(i));
      last_wa = WA;
    end
    tick();
    check("bub_full",  32'(bank_full), 32'b11);
    check("bub_dbank", 32'(done_bank), 0);
    pulse_rel(2'b10);
    check("bub_rel_ready", 32'(llr_ready), 1);

    // async reset at idx 100 of bank 1
    for (int i = 0; i < 100; i++) send(8'd12);
    check("pre_rst_wa", 32'(WA), 256 + 99);
    #2;
    rst = 1'b0;
    #1;
    check("arst_wr",    32'(wr_in), 0);
    check("arst_wa",    32'(WA), 0);
    check("arst_din",   32'(DIN), 0);
    check("arst_full",  32'(bank_full), 0);
    check("arst_ready", 32'(llr_ready), 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_full", 32'(bank_full), 0);
    send(8'd20);
    check("post_rst_wa",  32'(WA), 0);
    check("post_rst_din", 32'(DIN), 5);
    send(8'd24);
    check("post_rst_wa1", 32'(WA), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
